// File: rtl/sram_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : sram_fb_writer
// Brief    : Framebuffer write engine. Buffers producer pixel writes in a
//            small FIFO and issues them as timed SRAM write cycles
//            (SETUP / PULSE x WE_CYCLES / HOLD) only while the display
//            reader does not hold the bus. Strobes are active-high.
//            Optional rectangle-free linear fill engine is enabled by
//            defining SRAM_FB_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fb_writer #(
    parameter int DEPTH     = 4,
    parameter int WE_CYCLES = 2,
    parameter int ADDR_W    = 18
) (
    input  logic              clk100,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_be,
    input  logic              disp_busy,
    output logic              bus_own,
    output logic              bus_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_dout,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              ram_lb,
    output logic              ram_hb,
`ifdef SRAM_FB_FILL_EN
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [15:0]       fill_value,
    output logic              fill_busy,
`endif
    output logic              idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(WE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // FIFO storage (no reset needed: contents are only read when valid)
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [15:0]       fifo_data [DEPTH];
    logic [1:0]        fifo_be   [DEPTH];

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        be_q, be_d;
    logic              push, pop, empty;
    logic [PTR_W-1:0]  head;

`ifdef SRAM_FB_FILL_EN
    logic              fill_busy_q, fill_busy_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W-1:0] fill_rem_q, fill_rem_d;
    logic [15:0]       fill_val_q, fill_val_d;
`endif

    // Push is gated by the registered full flag only; a same-cycle pop never makes room.
    assign push  = wr_valid & ~full_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = rd_ptr_q[PTR_W-1:0];

    // FIFO data write port
    always_ff @(posedge clk100) begin
        if (push) begin
            fifo_addr[wr_ptr_q[PTR_W-1:0]] <= wr_addr;
            fifo_data[wr_ptr_q[PTR_W-1:0]] <= wr_data;
            fifo_be[wr_ptr_q[PTR_W-1:0]]   <= wr_be;
        end
    end

    // State register and all control/datapath flops
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
`ifdef SRAM_FB_FILL_EN
            fill_busy_q <= 1'b0;
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_val_q  <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
`ifdef SRAM_FB_FILL_EN
            fill_busy_q <= fill_busy_d;
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_val_q  <= fill_val_d;
`endif
        end
    end

    // Next-state logic: FSM sequencing, FIFO pop decision and pointer update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        pop     = 1'b0;
`ifdef SRAM_FB_FILL_EN
        fill_busy_d = fill_busy_q;
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_val_d  = fill_val_q;
        if (fill_start && !fill_busy_q) begin
            fill_busy_d = 1'b1;
            fill_addr_d = fill_base;
            fill_rem_d  = fill_len;
            fill_val_d  = fill_value;
        end
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SRAM_FB_FILL_EN
                // An active fill owns the IDLE decision until its count is exhausted
                if (fill_busy_q) begin
                    if (fill_rem_q == '0) begin
                        fill_busy_d = 1'b0;
                    end else if (!disp_busy) begin
                        addr_d      = fill_addr_q;
                        data_d      = fill_val_q;
                        be_d        = 2'b11;
                        fill_addr_d = fill_addr_q + ADDR_W'(1);
                        fill_rem_d  = fill_rem_q - ADDR_W'(1);
                        state_d     = ST_SETUP;
                    end
                end else
`endif
                if (!empty && !disp_busy) begin
                    pop = 1'b1;
                    // Entries with no byte enabled are dropped without touching the bus
                    if (fifo_be[head] != 2'b00) begin
                        addr_d  = fifo_addr[head];
                        data_d  = fifo_data[head];
                        be_d    = fifo_be[head];
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = C_PULSE_LOAD;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
        full_d   = (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]) &&
                   (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]);
    end

    // Output decode: strobes are a pure function of the state, so reset drops them at once
    always_comb begin
        bus_own  = (state_q != ST_IDLE);
        ram_ce   = bus_own;
        ram_we   = (state_q == ST_PULSE);
        ram_lb   = bus_own & be_q[0];
        ram_hb   = bus_own & be_q[1];
        ram_oe   = 1'b0;
        ram_addr = addr_q;
        ram_dout = data_q;
        wr_ready = ~full_q;
        idle     = empty && (state_q == ST_IDLE);
`ifdef SRAM_FB_FILL_EN
        // A pending fill also needs the bus, so it keeps the request up
        bus_req   = !empty || bus_own || fill_busy_q;
        fill_busy = fill_busy_q;
`else
        bus_req   = !empty || bus_own;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fb_writer
// Brief    : Self-checking bench for sram_fb_writer. A bus monitor decodes
//            each SRAM write cycle and compares it with a queue of expected
//            writes built from the accepted requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fb_writer;

    localparam int DEPTH     = 4;
    localparam int W         = 2;
    localparam int ADDR_W    = 18;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic [1:0]        be;
    } wr_t;

    logic              clk100 = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [1:0]        wr_be;
    logic              disp_busy;
    logic              bus_own, bus_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dout;
    logic              ram_ce, ram_oe, ram_we, ram_lb, ram_hb;
    logic              idle;
`ifdef SRAM_FB_FILL_EN
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base, fill_len;
    logic [15:0]       fill_value;
    logic              fill_busy;
`endif

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    always #5 clk100 = ~clk100;

    sram_fb_writer #(.DEPTH(DEPTH), .WE_CYCLES(W), .ADDR_W(ADDR_W)) dut (
        .clk100    (clk100),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .disp_busy (disp_busy),
        .bus_own   (bus_own),
        .bus_req   (bus_req),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_ce    (ram_ce),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_lb    (ram_lb),
        .ram_hb    (ram_hb),
`ifdef SRAM_FB_FILL_EN
        .fill_start(fill_start),
        .fill_base (fill_base),
        .fill_len  (fill_len),
        .fill_value(fill_value),
        .fill_busy (fill_busy),
`endif
        .idle      (idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk100);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
        int  n;
        bit  ok;
        wr_t e;
        n  = 0;
        ok = 1'b0;
        align();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        while (!ok && n < 2000) begin
            @(negedge clk100);
            if (wr_ready) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            check("push_timeout", 64'(ok), 64'(1));
            wr_valid = 1'b0;
        end else begin
            @(posedge clk100);
            #1;
            wr_valid = 1'b0;
            if (be != 2'b00) begin
                e.a = a; e.d = d; e.be = be;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk100);
            n++;
        end while (!(idle && !bus_own) && n < 3000);
        check("drain", 64'(idle), 64'(1));
        repeat (2) @(negedge clk100);
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        do begin
            @(negedge clk100);
            n++;
        end while (!ram_we && n < 200);
        check("we_seen", 64'(ram_we), 64'(1));
    endtask

    // Bus monitor: decode each write cycle and compare against the expected queue
    initial begin : monitor
        logic              in_txn, first_we, last_we, prev_busy, unstable;
        int                ce_len, we_len;
        logic [ADDR_W-1:0] t_a;
        logic [15:0]       t_d;
        logic [1:0]        t_be;
        wr_t               e;
        in_txn = 1'b0; prev_busy = 1'b0; unstable = 1'b0;
        first_we = 1'b0; last_we = 1'b0; ce_len = 0; we_len = 0;
        t_a = '0; t_d = '0; t_be = '0;
        forever begin
            @(negedge clk100);
            if (!reset_n) begin
                in_txn = 1'b0;
            end else begin
                check("oe_low", 64'(ram_oe), 64'(0));
                check("ce_is_own", 64'(ram_ce), 64'(bus_own));
                if (!bus_own) check("strobes_off", 64'({ram_we, ram_lb, ram_hb}), 64'(0));
                if (ram_ce && !in_txn) begin
                    in_txn   = 1'b1;
                    ce_len   = 1;
                    we_len   = int'(ram_we);
                    first_we = ram_we;
                    last_we  = ram_we;
                    unstable = 1'b0;
                    t_a = ram_addr; t_d = ram_dout; t_be = {ram_hb, ram_lb};
                    check("busy_at_start", 64'(prev_busy), 64'(0));
                end else if (ram_ce && in_txn) begin
                    ce_len++;
                    we_len += int'(ram_we);
                    last_we = ram_we;
                    if (ram_addr !== t_a || ram_dout !== t_d || {ram_hb, ram_lb} !== t_be)
                        unstable = 1'b1;
                end else if (!ram_ce && in_txn) begin
                    in_txn = 1'b0;
                    check("setup_we", 64'(first_we), 64'(0));
                    check("hold_we", 64'(last_we), 64'(0));
                    check("we_width", 64'(we_len), 64'(W));
                    check("ce_width", 64'(ce_len), 64'(W + 2));
                    check("bus_stable", 64'(unstable), 64'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(t_a), 64'({ADDR_W{1'b1}} + 64'(1)));
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(t_a), 64'(e.a));
                        check("wr_data", 64'(t_d), 64'(e.d));
                        check("wr_be", 64'(t_be), 64'(e.be));
                    end
                end
            end
            prev_busy = disp_busy;
        end
    end

    initial begin
        bit done;
        reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; disp_busy = 1'b0;
`ifdef SRAM_FB_FILL_EN
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
`endif
        // Reset state
        repeat (3) @(negedge clk100);
        check("rst_ready", 64'(wr_ready), 64'(1));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_strobes", 64'({bus_own, bus_req, ram_ce, ram_we, ram_lb, ram_hb, ram_oe}), 64'(0));
        #2 reset_n = 1'b1;

        // Single write latency
        push(18'h00123, 16'hBEEF, 2'b11);
        for (int k = 0; k <= W + 3; k++) begin
            @(negedge clk100);
            check($sformatf("lat_ce_%0d", k), 64'(ram_ce), 64'((k >= 1) && (k <= W + 2)));
            check($sformatf("lat_we_%0d", k), 64'(ram_we), 64'((k >= 2) && (k <= W + 1)));
            if (k == 1) begin
                check("lat_addr", 64'(ram_addr), 64'(18'h00123));
                check("lat_data", 64'(ram_dout), 64'(16'hBEEF));
                check("lat_lbhb", 64'({ram_lb, ram_hb}), 64'(2'b11));
            end
            if (k == W + 3) check("lat_idle", 64'(idle), 64'(1));
        end
        wait_idle();

        // Fill the FIFO while the display owns the bus
        align();
        disp_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(ADDR_W'(18'h100 + i), 16'(16'hA000 + i), 2'b11);
            if (i == DEPTH - 2) begin
                @(negedge clk100);
                check("ready_not_full", 64'(wr_ready), 64'(1));
            end
        end
        @(negedge clk100);
        check("ready_full", 64'(wr_ready), 64'(0));
        check("req_full", 64'(bus_req), 64'(1));
        fork
            push(18'h00200, 16'hA0FF, 2'b10);
            begin
                repeat (4) begin
                    @(negedge clk100);
                    check("stall_ready", 64'(wr_ready), 64'(0));
                    check("stall_ce", 64'(ram_ce), 64'(0));
                end
                align();
                disp_busy = 1'b0;
            end
        join
        wait_idle();

        // Bus yield: display grabs the bus during PULSE
        push(18'h00300, 16'h1111, 2'b11);
        push(18'h00301, 16'h2222, 2'b11);
        wait_we();
        align();
        disp_busy = 1'b1;
        begin
            int n;
            n = 0;
            do begin @(negedge clk100); n++; end while (ram_ce && n < 50);
        end
        repeat (6) begin
            @(negedge clk100);
            check("yield_ce", 64'(ram_ce), 64'(0));
            check("yield_req", 64'(bus_req), 64'(1));
        end
        align();
        disp_busy = 1'b0;
        wait_idle();

        // Byte enables
        push(18'h00400, 16'h3344, 2'b01);
        wait_idle();
        push(18'h00401, 16'h5566, 2'b00);
        @(negedge clk100);
        check("be0_idle_k0", 64'(idle), 64'(0));
        @(negedge clk100);
        check("be0_idle_k1", 64'(idle), 64'(1));
        check("be0_req_k1", 64'(bus_req), 64'(0));
        repeat (3) begin
            @(negedge clk100);
            check("be0_ce", 64'(ram_ce), 64'(0));
        end

        // Reset in the middle of a write pulse
        push(18'h00500, 16'h0A0A, 2'b11);
        push(18'h00501, 16'h0B0B, 2'b11);
        push(18'h00502, 16'h0C0C, 2'b11);
        wait_we();
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_we", 64'(ram_we), 64'(0));
        check("arst_ce", 64'(ram_ce), 64'(0));
        check("arst_ready", 64'(wr_ready), 64'(1));
        check("arst_idle", 64'(idle), 64'(1));
        check("arst_req", 64'(bus_req), 64'(0));
        repeat (2) @(negedge clk100);
        #2 reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk100);
            check("arst_quiet", 64'(ram_ce), 64'(0));
        end

        // Randomized traffic against a randomly busy display reader
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 3)) align();
                    push(ADDR_W'($urandom), 16'($urandom), 2'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    align();
                    disp_busy = ($urandom_range(0, 3) == 0);
                end
                disp_busy = 1'b0;
            end
        join
        wait_idle();

`ifdef SRAM_FB_FILL_EN
        // Fill across the address wrap with a FIFO entry arriving mid-fill
        begin
            wr_t e;
            int  n;
            align();
            fill_start = 1'b1; fill_base = 18'h3FFFE; fill_len = 18'd3; fill_value = 16'h0F0F;
            for (int i = 0; i < 3; i++) begin
                e.a = ADDR_W'(18'h3FFFE + i); e.d = 16'h0F0F; e.be = 2'b11;
                exp_q.push_back(e);
            end
            align();
            fill_start = 1'b0;
            @(negedge clk100);
            check("fill_busy_set", 64'(fill_busy), 64'(1));
            push(18'h00055, 16'h1234, 2'b11);
            wait_idle();
            n = 0;
            while (fill_busy && n < 100) begin @(negedge clk100); n++; end
            check("fill_busy_clr", 64'(fill_busy), 64'(0));
            align();
            fill_start = 1'b1; fill_len = '0;
            align();
            fill_start = 1'b0;
            @(negedge clk100);
            @(negedge clk100);
            check("fill_len0_done", 64'(fill_busy), 64'(0));
            repeat (4) begin
                @(negedge clk100);
                check("fill_len0_ce", 64'(ram_ce), 64'(0));
            end
        end
`endif

        repeat (2) @(negedge clk100);
        check("leftover_writes", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_fb_writer.md
Name: sram_fb_writer

Overview:
Framebuffer write engine. It is the writing end of the SRAM pixel store that the display path reads. It accepts pixel write requests from a producer (drawing logic or CPU) over a valid/ready handshake and buffers them in a small FIFO. Buffered requests are issued as timed SRAM write cycles, only while the display reader does not hold the bus. Its ram_* outputs are active-high and meet the display reader's outputs at the top-level bus mux, ahead of the active-low pad inversion.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two and at least 2.
WE_CYCLES, 2, clk100 cycles that ram_we stays high per write; minimum 1.
ADDR_W, 18, SRAM word-address width.

Ports:
clk100  in  1  bus clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
wr_valid  in  1  producer request valid.
wr_ready  out  1  FIFO can accept a request; equals not-full.
wr_addr  in  ADDR_W  target word address.
wr_data  in  16  pixel word.
wr_be  in  2  byte enables: bit0 = low byte, bit1 = high byte.
disp_busy  in  1  display reader owns the bus this cycle.
bus_own  out  1  this block drives the SRAM bus; the top-level mux selects on it.
bus_req  out  1  FIFO is non-empty or a write is in progress.
ram_addr  out  ADDR_W  SRAM address.
ram_dout  out  16  SRAM write data.
ram_ce, ram_oe, ram_we, ram_lb, ram_hb  out  1 each  active-high SRAM strobes.
idle  out  1  FIFO is empty and FSM is in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-write):
  - FIFO emptied; FSM returns to IDLE.
  - All ram_* outputs, bus_own and bus_req go to 0.
  - wr_ready goes to 1; idle goes to 1.
- Push: occurs on a clk100 edge where wr_valid and wr_ready are both 1.
  - wr_ready is computed from the registered full flag only.
  - A pop in the same cycle does not make room while the FIFO is full.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full when the index bits are equal and the MSBs differ.
  - empty when the pointers are equal.
- FSM states:
  - IDLE: if the FIFO is non-empty and disp_busy=0, pop the head into the output registers.
    - If the popped entry has wr_be≠0, go to SETUP.
    - If wr_be=0, discard the entry; stay in IDLE with no bus activity (one cycle consumed).
    - If disp_busy=1, stay in IDLE; the FIFO holds.
  - SETUP (1 cycle): ram_ce=1; ram_addr, ram_dout, ram_lb, ram_hb valid; ram_we=0.
  - PULSE (WE_CYCLES cycles): as SETUP, plus ram_we=1. Uses a down-counter.
  - HOLD (1 cycle): ram_we=0; ram_ce, address, data and byte strobes unchanged. Then go to IDLE.
- Once SETUP is entered, the write always completes; disp_busy is sampled only in IDLE.
- bus_own = 1 in SETUP, PULSE and HOLD.
- ram_ce, ram_lb, ram_hb and ram_we are 0 whenever bus_own=0.
- ram_addr and ram_dout hold their last values while idle.
- ram_oe is always 0.
- Latency: with the FIFO empty and disp_busy=0, a request accepted on edge E0 gives:
  - SETUP from E1.
  - ram_we high from E2 through E(1+WE_CYCLES).
  - HOLD at E(2+WE_CYCLES).
  - IDLE at E(3+WE_CYCLES).
- Back-to-back throughput: one write per WE_CYCLES+3 cycles.
- Entries are written strictly in FIFO order.
- bus_req = (not empty) or bus_own.

Optional Feature:
SRAM_FB_FILL_EN
- Defined: adds ports fill_start (in, 1), fill_base (in, ADDR_W), fill_len (in, ADDR_W), fill_value (in, 16), fill_busy (out, 1).
  - fill_start pulsed while fill_busy=0 latches all fill parameters and sets fill_busy.
  - In IDLE, an active fill has priority over the FIFO. Each step writes fill_value with both byte enables to base+i, for i = 0 to fill_len-1.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - fill_len=0 completes immediately with no bus cycles.
  - fill_busy clears in the IDLE cycle after the last HOLD.
  - FIFO pushes are still accepted during a fill and drain after it.
  - fill_start while fill_busy=1 is ignored.
- Undefined: these ports and this logic are absent.

Test Plan:
- Single write: addr=0x00123, data=0xBEEF, be=2'b11, disp_busy=0, WE_CYCLES=2 -> ce from E1; we high at E2 and E3; HOLD at E4; ram_addr=0x00123, ram_dout=0xBEEF, lb=hb=1 throughout; idle=1 at E5.
- Fill FIFO: 5 pushes with disp_busy=1, DEPTH=4 -> wr_ready=0 after the 4th push; 5th push stalls; no ram_ce. Release disp_busy -> 4 writes in order, then the 5th.
- Bus yield: disp_busy rises during PULSE -> current write completes with full we width; the next entry waits until disp_busy=0.
- Byte enables: be=2'b01 -> lb=1, hb=0. be=2'b00 -> entry consumed in 1 cycle with ram_ce never asserted.
- Reset mid-PULSE: reset_n low -> ram_we and ram_ce drop with no clock edge; after release wr_ready=1, idle=1, and none of the old entries are written.
- (SRAM_FB_FILL_EN) base=0x3FFFE, len=3, value=0x0F0F -> writes to 0x3FFFE, 0x3FFFF, 0x00000; a FIFO entry pushed mid-fill is written after 0x00000.
